// File: rtl/rr_mux8_arbiter.sv
// Eight-requester round-robin arbiter with a registered 8:1 data mux.
// One transfer in flight at a time; the search pointer advances past each completed grant.
module rr_mux8_arbiter #(
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      req,
  input  logic [8*DW-1:0] in_data,
  input  logic            out_ready,
  output logic [7:0]      gnt,
  output logic [2:0]      sel,
  output logic [DW-1:0]   out_data,
  output logic            out_valid,
  output logic [15:0]     xfer_cnt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      sel_q, sel_d;
  logic [7:0]      gnt_q, gnt_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   data_q, data_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            found;
  logic [2:0]      pick;
  logic [2:0]      idx;

  // First set request at or above ptr, wrapping through 7 back to ptr-1.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int unsigned off = 0; off < 8; off++) begin
      idx = ptr_q + off[2:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = pick;
          gnt_d   = 8'b1 << pick;
          valid_d = 1'b1;
          data_d  = in_data[pick*DW +: DW];
        end
      end
      GRANT: begin
        if (out_ready) begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = sel_q + 3'd1;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign xfer_cnt  = cnt_q;

endmodule
